periph_bus_master: RTL and testbench

Initiator side of the team's simple peripheral register bus (address / byte_en / data / rw / clken / q). Accepts single load/store requests from the CPU core over a valid/ready handshake, performs lane alignment, byte-enable generation and misalignment checking, runs exactly one bus cycle on the peripheral side, then returns a one-cycle response with sign- or zero-extended read data. Sits between the core's data port and the GPIO and other custom peripherals.

---
 rtl/periph_bus_master_if.sv | 37 +++
 rtl/periph_bus_master.sv | 184 ++++++++++++++++++
 tb/tb_periph_bus_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/periph_bus_master_if.sv
// Signal bundle between the CPU data port, periph_bus_master and the peripheral register bus.
// The master modport is the bus master's view; slave is the core/peripheral side.
interface periph_bus_master_if #(
  parameter int ADDR_W = 8
);
  // CPU request/response side
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  // Peripheral register bus side
  logic [ADDR_W-1:0] address;
  logic [3:0]        byte_en;
  logic [31:0]       data;
  logic              rw;
  logic              clken;
  logic [31:0]       q;

  modport master (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, q,
    output req_ready, resp_valid, resp_rdata, resp_err,
           address, byte_en, data, rw, clken
  );

  modport slave (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, q,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           address, byte_en, data, rw, clken
  );
endinterface

// File: rtl/periph_bus_master.sv
// Single-outstanding load/store bridge from the core data port onto the peripheral register bus:
// lane alignment, byte enables, misalignment trap, one bus strobe, one-cycle extended response.
module periph_bus_master #(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input logic                 clk,
  input logic                 reset,
  periph_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_READ_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [1:0]        r_lane;
  logic [1:0]        r_size;
  logic              r_signed;

  logic              r_req_ready;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;
  logic [ADDR_W-1:0] r_address;
  logic [3:0]        r_byte_en;
  logic [31:0]       r_data;
  logic              r_rw;
  logic              r_clken;

  logic              w_misaligned;
  logic [3:0]        w_byte_en;
  logic [31:0]       w_data;
  logic [31:0]       w_rdata;
  logic              w_unused_addr;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lane[0];
      2'd2:    return lane != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    return 4'b0001 << lane;
      2'd1:    return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    return {4{wdata[7:0]}};
      2'd1:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] q, input logic [1:0] lane,
                                          input logic [1:0] size, input logic sgn);
    logic [31:0] s;
    s = q >> {lane, 3'b000};
    case (size)
      2'd0:    return {{24{sgn & s[7]}}, s[7:0]};
      2'd1:    return {{16{sgn & s[15]}}, s[15:0]};
      default: return q;
    endcase
  endfunction

  assign w_misaligned  = misaligned(bus.req_size, bus.req_addr[1:0]);
  assign w_byte_en     = lane_enables(bus.req_size, bus.req_addr[1:0]);
  assign w_data        = replicate(bus.req_size, bus.req_wdata);
  assign w_rdata       = extract(bus.q, r_lane, r_size, r_signed);
  assign w_unused_addr = ^bus.req_addr[31:ADDR_W+2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_lane       <= '0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_address    <= '0;
      r_byte_en    <= '0;
      r_data       <= '0;
      r_rw         <= 1'b1;
      r_clken      <= 1'b0;
    end else begin
      // Bus strobe and response are single-cycle pulses; idle bus values unless a state overrides.
      r_resp_valid <= 1'b0;
      r_clken      <= 1'b0;
      r_rw         <= 1'b1;
      r_byte_en    <= '0;
      r_data       <= '0;

      unique case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_lane      <= bus.req_addr[1:0];
            r_size      <= bus.req_size;
            r_signed    <= bus.req_signed;
            r_req_ready <= 1'b0;
            if (w_misaligned) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_address <= bus.req_addr[ADDR_W+1:2];
              r_byte_en <= w_byte_en;
              r_clken   <= 1'b1;
              if (bus.req_we) begin
                r_rw    <= 1'b0;
                r_data  <= w_data;
                r_state <= S_WRITE;
              end else begin
                r_state <= S_READ;
              end
            end
          end
        end

        S_WRITE: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end

        S_READ: begin
          r_cnt   <= LAT;
          r_state <= S_READ_WAIT;
        end

        // q is only meaningful in the final wait cycle; earlier values are ignored.
        S_READ_WAIT: begin
          r_cnt <= (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_resp_rdata <= w_rdata;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end

        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.address    = r_address;
  assign bus.byte_en    = r_byte_en;
  assign bus.data       = r_data;
  assign bus.rw         = r_rw;
  assign bus.clken      = r_clken;

endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master: instance a uses READ_LATENCY=1, instance b READ_LATENCY=3.
// A transaction-level model predicts every output each cycle; directed literals pin the model.
module tb_periph_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  periph_bus_master_if #(.ADDR_W(8)) ifa ();
  periph_bus_master_if #(.ADDR_W(8)) ifb ();

  periph_bus_master #(.ADDR_W(8), .READ_LATENCY(1)) dut_a (.clk(clk), .reset(rst), .bus(ifa.master));
  periph_bus_master #(.ADDR_W(8), .READ_LATENCY(3)) dut_b (.clk(clk), .reset(rst), .bus(ifb.master));

  // stimulus-side variables (index 0 -> a, 1 -> b)
  logic        v_valid [2];
  logic        v_we    [2];
  logic        v_sgn   [2];
  logic [31:0] v_addr  [2];
  logic [1:0]  v_size  [2];
  logic [31:0] v_wd    [2];
  logic [31:0] v_q     [2];
  logic [31:0] v_qgood [2];

  assign ifa.req_valid = v_valid[0];  assign ifb.req_valid = v_valid[1];
  assign ifa.req_we = v_we[0];        assign ifb.req_we = v_we[1];
  assign ifa.req_addr = v_addr[0];    assign ifb.req_addr = v_addr[1];
  assign ifa.req_size = v_size[0];    assign ifb.req_size = v_size[1];
  assign ifa.req_signed = v_sgn[0];   assign ifb.req_signed = v_sgn[1];
  assign ifa.req_wdata = v_wd[0];     assign ifb.req_wdata = v_wd[1];
  assign ifa.q = v_q[0];              assign ifb.q = v_q[1];

  logic        o_ready [2];
  logic        o_valid [2];
  logic [31:0] o_rdata [2];
  logic        o_err   [2];
  logic [7:0]  o_adr   [2];
  logic [3:0]  o_be    [2];
  logic [31:0] o_data  [2];
  logic        o_rw    [2];
  logic        o_clken [2];

  assign o_ready[0] = ifa.req_ready;   assign o_ready[1] = ifb.req_ready;
  assign o_valid[0] = ifa.resp_valid;  assign o_valid[1] = ifb.resp_valid;
  assign o_rdata[0] = ifa.resp_rdata;  assign o_rdata[1] = ifb.resp_rdata;
  assign o_err[0] = ifa.resp_err;      assign o_err[1] = ifb.resp_err;
  assign o_adr[0] = ifa.address;       assign o_adr[1] = ifb.address;
  assign o_be[0] = ifa.byte_en;        assign o_be[1] = ifb.byte_en;
  assign o_data[0] = ifa.data;         assign o_data[1] = ifb.data;
  assign o_rw[0] = ifa.rw;             assign o_rw[1] = ifb.rw;
  assign o_clken[0] = ifa.clken;       assign o_clken[1] = ifb.clken;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic string nm(input int k, input string s);
    return {(k == 1) ? "b." : "a.", s};
  endfunction

  function automatic int rl(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  // ---------------- transaction model ----------------
  int          cyc = 0;
  int          m_acc  [2];
  int          m_a    [2];
  bit          m_busy [2];
  bit          m_we   [2];
  bit          m_sgn  [2];
  bit          m_mis  [2];
  logic [31:0] m_addr [2];
  logic [1:0]  m_size [2];
  logic [31:0] m_wd   [2];
  logic [31:0] m_rd   [2];
  bit          m_err  [2];
  logic [7:0]  m_adr  [2];
  int          m_stb  [2];
  int          d_stb  [2];
  int          rem    [2];

  // cycles from accept to the first cycle the master is ready again
  function automatic int done_d(input int k);
    return m_mis[k] ? 1 : (m_we[k] ? 2 : 2 + rl(k));
  endfunction

  function automatic logic [3:0] be_of(input logic [31:0] a, input logic [1:0] sz);
    int nb;
    int lo;
    logic [3:0] r;
    nb = 1 << sz;
    lo = int'(a[1:0]);
    r = '0;
    for (int i = 0; i < 4; i++) if (i >= lo && i < lo + nb) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] rep_of(input logic [31:0] wd, input logic [1:0] sz);
    int nb;
    logic [31:0] r;
    nb = 1 << sz;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ext_of(input logic [31:0] q, input logic [31:0] a,
                                         input logic [1:0] sz, input bit sg);
    int nb;
    longint v;
    longint mask;
    if (sz == 2'd2) return q;
    nb = (sz == 2'd0) ? 1 : 2;
    mask = (longint'(1) << (8 * nb)) - 1;
    v = longint'(q >> (8 * int'(a[1:0]))) & mask;
    if (sg && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 1'b0;
        m_rd[k] = '0;
        m_err[k] = 1'b0;
        m_adr[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_busy[k] && (cyc - m_a[k] >= done_d(k))) m_busy[k] = 1'b0;
        if (!m_busy[k] && v_valid[k] === 1'b1) begin
          m_busy[k] = 1'b1;
          m_a[k] = cyc + 1;
          m_we[k] = v_we[k];
          m_sgn[k] = v_sgn[k];
          m_addr[k] = v_addr[k];
          m_size[k] = v_size[k];
          m_wd[k] = v_wd[k];
          m_mis[k] = (v_size[k] == 2'd3) ? 1'b1 : ((int'(v_addr[k][1:0]) % (1 << v_size[k])) != 0);
          if (!m_mis[k]) m_adr[k] = v_addr[k][9:2];
          m_acc[k]++;
        end
      end
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (m_busy[k] && (cyc - m_a[k] == done_d(k) - 1)) begin
          m_err[k] = m_mis[k];
          m_rd[k] = (m_mis[k] || m_we[k]) ? 32'h0 : ext_of(v_qgood[k], m_addr[k], m_size[k], m_sgn[k]);
        end
      end
    end
  end

  // per-cycle compare of every output against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int d;
      bit act;
      bit stb;
      d = cyc - m_a[k];
      act = !rst && m_busy[k] && (d < done_d(k));
      stb = act && !m_mis[k] && (d == 0);
      chk(nm(k, "req_ready"), 32'(o_ready[k]), 32'(!act));
      chk(nm(k, "resp_valid"), 32'(o_valid[k]), 32'(act && (d == done_d(k) - 1)));
      chk(nm(k, "resp_rdata"), o_rdata[k], rst ? 32'h0 : m_rd[k]);
      chk(nm(k, "resp_err"), 32'(o_err[k]), rst ? 32'h0 : 32'(m_err[k]));
      chk(nm(k, "address"), 32'(o_adr[k]), rst ? 32'h0 : 32'(m_adr[k]));
      chk(nm(k, "byte_en"), 32'(o_be[k]), stb ? 32'(be_of(m_addr[k], m_size[k])) : 32'h0);
      chk(nm(k, "data"), o_data[k], (stb && m_we[k]) ? rep_of(m_wd[k], m_size[k]) : 32'h0);
      chk(nm(k, "rw"), 32'(o_rw[k]), stb ? 32'(!m_we[k]) : 32'h1);
      chk(nm(k, "clken"), 32'(o_clken[k]), 32'(stb));
      if (stb) m_stb[k]++;
      if (o_clken[k] === 1'b1) d_stb[k]++;
    end
  end

  // peripheral: q carries the real word only in the cycle READ_LATENCY after the strobe
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rem[k] = 0;
        v_q[k] = 32'hDEAD_BEEF;
      end else if (o_clken[k] === 1'b1 && o_rw[k] === 1'b1) begin
        rem[k] = rl(k);
        v_q[k] = ~v_qgood[k];
      end else if (rem[k] == 1) begin
        rem[k] = 0;
        v_q[k] = v_qgood[k];
      end else begin
        if (rem[k] > 1) rem[k]--;
        v_q[k] = ~v_qgood[k];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int k, input bit we, input logic [31:0] a, input logic [1:0] sz,
                      input bit sg, input logic [31:0] wd, input bit keep);
    int n0;
    n0 = m_acc[k];
    v_valid[k] = 1'b1;
    v_we[k] = we;
    v_addr[k] = a;
    v_size[k] = sz;
    v_sgn[k] = sg;
    v_wd[k] = wd;
    for (int t = 0; t < 40 && m_acc[k] == n0; t++) begin
      @(posedge clk);
      #1;
    end
    if (m_acc[k] == n0) begin
      checks++;
      errors++;
      $display("FAIL %s accept timeout", nm(k, "handshake"));
    end
    if (!keep) begin
      v_valid[k] = 1'b0;
      v_we[k] = ~we;
      v_addr[k] = 32'hFFFF_FFFF;
      v_size[k] = 2'd3;
      v_sgn[k] = ~sg;
      v_wd[k] = ~wd;
    end
  endtask

  task automatic wait_idle(input int k);
    for (int t = 0; t < 60 && m_busy[k] && (cyc - m_a[k] < done_d(k)); t++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      v_valid[k] = 1'b0; v_we[k] = 1'b0; v_sgn[k] = 1'b0;
      v_addr[k] = '0; v_size[k] = '0; v_wd[k] = '0;
    end
    v_qgood[0] = 32'h0080_F000;
    v_qgood[1] = 32'h8001_7F22;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("a.reset_ready", 32'(o_ready[0]), 32'h1);
    chk("a.reset_rw", 32'(o_rw[0]), 32'h1);
    chk("a.reset_clken", 32'(o_clken[0]), 32'h0);

    // word store
    send(0, 1'b1, 32'h4, 2'd2, 1'b0, 32'hA5A5_1234, 1'b0);
    chk("a.ws_clken", 32'(o_clken[0]), 32'h1);
    chk("a.ws_rw", 32'(o_rw[0]), 32'h0);
    chk("a.ws_address", 32'(o_adr[0]), 32'h1);
    chk("a.ws_byte_en", 32'(o_be[0]), 32'hF);
    chk("a.ws_data", o_data[0], 32'hA5A5_1234);
    @(posedge clk); #1;
    chk("a.ws_resp_valid", 32'(o_valid[0]), 32'h1);
    chk("a.ws_resp_err", 32'(o_err[0]), 32'h0);
    wait_idle(0);

    // byte and half stores
    send(0, 1'b1, 32'h6, 2'd0, 1'b0, 32'hFFFF_FF5A, 1'b0);
    chk("a.bs_byte_en", 32'(o_be[0]), 32'h4);
    chk("a.bs_data", o_data[0], 32'h5A5A_5A5A);
    wait_idle(0);
    send(0, 1'b1, 32'h2, 2'd1, 1'b0, 32'h1234_BEEF, 1'b0);
    chk("a.hs_byte_en", 32'(o_be[0]), 32'hC);
    chk("a.hs_data", o_data[0], 32'hBEEF_BEEF);
    wait_idle(0);

    // loads, q = 0x0080F000
    send(0, 1'b0, 32'h5, 2'd0, 1'b1, 32'h0, 1'b0);
    chk("a.lb_byte_en", 32'(o_be[0]), 32'h2);
    repeat (2) @(posedge clk);
    #1;
    chk("a.lbs_resp_valid", 32'(o_valid[0]), 32'h1);
    chk("a.lbs_rdata", o_rdata[0], 32'hFFFF_FFF0);
    wait_idle(0);
    send(0, 1'b0, 32'h5, 2'd0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("a.lbu_rdata", o_rdata[0], 32'h0000_00F0);
    wait_idle(0);
    send(0, 1'b0, 32'h6, 2'd1, 1'b1, 32'h0, 1'b0);
    wait_idle(0);
    send(0, 1'b0, 32'h4, 2'd1, 1'b1, 32'h0, 1'b0);
    wait_idle(0);

    // misaligned / illegal
    send(0, 1'b0, 32'h3, 2'd1, 1'b0, 32'h0, 1'b0);
    chk("a.mis_h_valid", 32'(o_valid[0]), 32'h1);
    chk("a.mis_h_err", 32'(o_err[0]), 32'h1);
    chk("a.mis_h_rdata", o_rdata[0], 32'h0);
    chk("a.mis_h_clken", 32'(o_clken[0]), 32'h0);
    wait_idle(0);
    send(0, 1'b1, 32'h2, 2'd2, 1'b0, 32'h1111_2222, 1'b0);
    chk("a.mis_w_err", 32'(o_err[0]), 32'h1);
    chk("a.mis_w_clken", 32'(o_clken[0]), 32'h0);
    wait_idle(0);
    send(0, 1'b0, 32'h0, 2'd3, 1'b0, 32'h0, 1'b0);
    wait_idle(0);

    // back-to-back with req_valid held high
    send(0, 1'b1, 32'h8, 2'd2, 1'b0, 32'h1122_3344, 1'b1);
    send(0, 1'b0, 32'h5, 2'd0, 1'b0, 32'h0, 1'b1);
    send(0, 1'b0, 32'h6, 2'd1, 1'b1, 32'h0, 1'b0);
    wait_idle(0);
    send(1, 1'b1, 32'hC, 2'd0, 1'b0, 32'h0000_0077, 1'b1);
    send(1, 1'b0, 32'h5, 2'd0, 1'b0, 32'h0, 1'b1);
    send(1, 1'b0, 32'h6, 2'd1, 1'b1, 32'h0, 1'b0);
    wait_idle(1);

    // READ_LATENCY = 3 load response timing
    send(1, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("b.l3_early_valid", 32'(o_valid[1]), 32'h0);
    @(posedge clk); #1;
    chk("b.l3_resp_valid", 32'(o_valid[1]), 32'h1);
    chk("b.l3_rdata", o_rdata[1], 32'h8001_7F22);
    wait_idle(1);

    // reset while the store strobe is high
    send(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0);
    chk("a.rst_pre_clken", 32'(o_clken[0]), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("a.rst_async_clken", 32'(o_clken[0]), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset during READ_WAIT on b
    send(1, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    chk("b.rst_clken", 32'(o_clken[1]), 32'h0);
    chk("b.rst_ready", 32'(o_ready[1]), 32'h1);
    chk("b.rst_valid", 32'(o_valid[1]), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("b.post_rst_ready", 32'(o_ready[1]), 32'h1);
    send(1, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("b.post_rst_valid", 32'(o_valid[1]), 32'h1);
    chk("b.post_rst_rdata", o_rdata[1], 32'h8001_7F22);
    wait_idle(1);
    send(0, 1'b1, 32'h14, 2'd0, 1'b0, 32'h0000_00AB, 1'b0);
    chk("a.post_rst_data", o_data[0], 32'hABAB_ABAB);
    wait_idle(0);
    repeat (2) @(posedge clk);
    #1;

    chk("a.strobe_count", 32'(d_stb[0]), 32'(m_stb[0]));
    chk("b.strobe_count", 32'(d_stb[1]), 32'(m_stb[1]));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
